// File: rtl/mul_ctrl.sv
// RV32M multiply-group sequencer around the unsigned iterative shift-add multiplier.
// Optional last-result cache enabled by defining MUL_CTRL_FUSE_EN.
module mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld_i,
  output logic        req_rdy_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic [4:0]  req_tag_i,
  output logic        rsp_vld_o,
  input  logic        rsp_rdy_i,
  output logic [31:0] rsp_data_o,
  output logic [4:0]  rsp_tag_o,
  output logic        mul_vld_o,
  output logic [31:0] mul1_o,
  output logic [31:0] mul2_o,
  input  logic [63:0] mul_res_i,
  input  logic        mul_rdy_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} op_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [31:0] m1_q, m1_d, m2_q, m2_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  tag_q, tag_d;

  logic        s1, s2;
  logic [31:0] mag1, mag2;
  logic [63:0] prod;

`ifdef MUL_CTRL_FUSE_EN
  typedef enum logic [1:0] {MODE_UU, MODE_SU, MODE_SS} mode_e;

  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic        c_vld_q, c_vld_d;
  logic [31:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d;
  mode_e       c_mode_q, c_mode_d;
  logic [63:0] c_p_q, c_p_d;
  mode_e       req_mode, cur_mode;
  logic        hit;
  logic [31:0] hit_data;
`endif

  always_comb begin
    s1   = req_rs1_i[31] & ((req_op_i == OP_MULH) || (req_op_i == OP_MULHSU));
    s2   = req_rs2_i[31] & (req_op_i == OP_MULH);
    mag1 = s1 ? (~req_rs1_i + 32'd1) : req_rs1_i;
    mag2 = s2 ? (~req_rs2_i + 32'd1) : req_rs2_i;
    prod = neg_q ? (~mul_res_i + 64'd1) : mul_res_i;
  end

`ifdef MUL_CTRL_FUSE_EN
  // MUL hits regardless of mode: the low word of the product is sign-agnostic.
  always_comb begin
    case (req_op_i)
      OP_MULH:   req_mode = MODE_SS;
      OP_MULHSU: req_mode = MODE_SU;
      default:   req_mode = MODE_UU;
    endcase
    case (op_q)
      OP_MULH:   cur_mode = MODE_SS;
      OP_MULHSU: cur_mode = MODE_SU;
      default:   cur_mode = MODE_UU;
    endcase
    hit      = c_vld_q && (req_rs1_i == c_rs1_q) && (req_rs2_i == c_rs2_q) &&
               ((req_op_i == OP_MUL) || (req_mode == c_mode_q));
    hit_data = (req_op_i == OP_MUL) ? c_p_q[31:0] : c_p_q[63:32];
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    data_d    = data_q;
    tag_d     = tag_q;
    req_rdy_o = 1'b0;
    rsp_vld_o = 1'b0;
    mul_vld_o = 1'b0;
`ifdef MUL_CTRL_FUSE_EN
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    c_vld_d   = c_vld_q;
    c_rs1_d   = c_rs1_q;
    c_rs2_d   = c_rs2_q;
    c_mode_d  = c_mode_q;
    c_p_d     = c_p_q;
`endif
    case (state_q)
      IDLE: begin
        req_rdy_o = ~rst;
        if (req_vld_i) begin
          op_d  = req_op_i;
          tag_d = req_tag_i;
          neg_d = s1 ^ s2;
`ifdef MUL_CTRL_FUSE_EN
          rs1_d = req_rs1_i;
          rs2_d = req_rs2_i;
          if (hit) begin
            data_d  = hit_data;
            state_d = RESP;
          end else begin
            m1_d    = mag1;
            m2_d    = mag2;
            state_d = ISSUE;
          end
`else
          m1_d    = mag1;
          m2_d    = mag2;
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        mul_vld_o = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mul_rdy_i) begin
          data_d  = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
          state_d = RESP;
`ifdef MUL_CTRL_FUSE_EN
          c_vld_d  = 1'b1;
          c_rs1_d  = rs1_q;
          c_rs2_d  = rs2_q;
          c_mode_d = cur_mode;
          c_p_d    = prod;
`endif
        end
      end
      RESP: begin
        rsp_vld_o = 1'b1;
        if (rsp_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      m1_q     <= '0;
      m2_q     <= '0;
      data_q   <= '0;
      tag_q    <= '0;
`ifdef MUL_CTRL_FUSE_EN
      rs1_q    <= '0;
      rs2_q    <= '0;
      c_vld_q  <= 1'b0;
      c_rs1_q  <= '0;
      c_rs2_q  <= '0;
      c_mode_q <= MODE_UU;
      c_p_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      m1_q     <= m1_d;
      m2_q     <= m2_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
`ifdef MUL_CTRL_FUSE_EN
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      c_vld_q  <= c_vld_d;
      c_rs1_q  <= c_rs1_d;
      c_rs2_q  <= c_rs2_d;
      c_mode_q <= c_mode_d;
      c_p_q    <= c_p_d;
`endif
    end
  end

  assign mul1_o     = m1_q;
  assign mul2_o     = m2_q;
  assign rsp_data_o = data_q;
  assign rsp_tag_o  = tag_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl with a behavioural shift-add multiplier responder.
`timescale 1ns/1ps
module tb_mul_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld_i, req_rdy_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_rs1_i, req_rs2_i;
  logic [4:0]  req_tag_i;
  logic        rsp_vld_o, rsp_rdy_i;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_tag_o;
  logic        mul_vld_o;
  logic [31:0] mul1_o, mul2_o;
  logic [63:0] mul_res_i = '0;
  logic        mul_rdy_i = 1'b0;

  mul_ctrl dut (
    .clk(clk), .rst(rst),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_op_i(req_op_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_tag_i(req_tag_i),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_data_o(rsp_data_o),
    .rsp_tag_o(rsp_tag_o), .mul_vld_o(mul_vld_o), .mul1_o(mul1_o),
    .mul2_o(mul2_o), .mul_res_i(mul_res_i), .mul_rdy_i(mul_rdy_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] tag; logic [31:0] data; } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_m1 = '0, exp_m2 = '0;
  int          mul_pulses = 0;
  bit          mul_prev = 1'b0;
  bit          rand_rdy = 1'b0;

  // Multiplier stand-in: rdy pulse 2+popcount(smaller operand) cycles after the issue cycle.
  bit busy = 1'b0;
  int cnt = 0;
  always @(posedge clk) begin
    mul_rdy_i <= 1'b0;
    if (rst) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (mul_vld_o) begin
      busy      <= 1'b1;
      cnt       <= ((mul1_o < mul2_o) ? $countones(mul1_o) : $countones(mul2_o)) + 1;
      mul_res_i <= 64'(mul1_o) * 64'(mul2_o);
    end else if (busy) begin
      if (cnt == 1) begin
        mul_rdy_i <= 1'b1;
        busy      <= 1'b0;
      end
      cnt <= cnt - 1;
    end
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [65:0] x, y, p;
    x = {{34{a[31] & ((op == 2'd1) || (op == 2'd2))}}, a};
    y = {{34{b[31] & (op == 2'd1)}}, b};
    p = x * y;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (mul_vld_o) begin
        mul_pulses++;
        checks++;
        if (mul_prev || mul1_o !== exp_m1 || mul2_o !== exp_m2) begin
          errors++;
          $display("FAIL issue: mul1=%h mul2=%h repeat=%0b, required %h %h single pulse",
                   mul1_o, mul2_o, mul_prev, exp_m1, exp_m2);
        end
      end
      if (rsp_vld_o && rsp_rdy_i) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: data=%h tag=%0d, required no response",
                   rsp_data_o, rsp_tag_o);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_data_o !== mon_e.data || rsp_tag_o !== mon_e.tag) begin
            errors++;
            $display("FAIL rsp: data=%h tag=%0d, required data=%h tag=%0d",
                     rsp_data_o, rsp_tag_o, mon_e.data, mon_e.tag);
          end
        end
      end
    end
    mul_prev = mul_vld_o;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rsp_rdy_i = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] expv);
    int n = 0;
    req_vld_i = 1'b1;
    req_op_i  = op;
    req_rs1_i = a;
    req_rs2_i = b;
    req_tag_i = tag;
    @(negedge clk);
    while (!req_rdy_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 64'(req_rdy_o), 64'd1);
    if (req_rdy_o) begin
      sb.push_back('{tag: tag, data: expv});
      exp_m1 = (a[31] && (op == 2'd1 || op == 2'd2)) ? 32'd0 - a : a;
      exp_m2 = (b[31] && op == 2'd1) ? 32'd0 - b : b;
    end
    @(posedge clk);
    #1;
    req_vld_i = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_vld_o && lat < 500);
    chk("rsp_timeout", 64'(rsp_vld_o), 64'd1);
  endtask

  logic [1:0]  d_op [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
  logic [31:0] d_a  [6] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_b  [6] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_r  [6] = '{32'h0000_002A, 32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'hFFFF_FFFE};

  initial begin
    int lat, p0, n;
    bit seen;
    logic [1:0]  op;
    logic [31:0] a, b;
    rst = 1'b1; req_vld_i = 1'b0; req_op_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    req_tag_i = '0; rsp_rdy_i = 1'b1;

    @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", 64'(req_rdy_o), 64'd0);
    chk("rst_rsp", {rsp_vld_o, rsp_tag_o, rsp_data_o}, 64'd0);
    chk("rst_mul", {mul_vld_o, mul1_o}, 64'd0);
    chk("rst_mul2", 64'(mul2_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("req_rdy_after_rst", 64'(req_rdy_o), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      p0 = mul_pulses;
      send(d_op[i], d_a[i], d_b[i], (i == 0) ? 5'd3 : 5'(i + 10), d_r[i]);
      wait_rsp(lat);
      @(posedge clk); #1;
      chk("issue_count", 64'(mul_pulses - p0), 64'd1);
    end

    // Zero operand: fixed 4-cycle latency, then backpressure hold.
    rsp_rdy_i = 1'b0;
    send(2'd0, 32'h0, 32'h1234_5678, 5'd7, 32'h0);
    wait_rsp(lat);
    chk("zero_latency", 64'(lat), 64'd4);
    repeat (10) begin
      @(negedge clk);
      chk("hold", {rsp_vld_o, req_rdy_o, rsp_tag_o, rsp_data_o}, {25'd0, 1'b1, 1'b0, 5'd7, 32'd0});
    end
    @(posedge clk); #1;
    rsp_rdy_i = 1'b1;
    @(posedge clk); #1;

    // Reset during WAIT discards the in-flight request.
    send(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_vld_o) seen = 1'b1;
    end
    chk("no_rsp_after_rst", 64'(seen), 64'd0);
    @(posedge clk); #1;
    send(2'd0, 32'd3, 32'd5, 5'd4, 32'h0000_000F);
    wait_rsp(lat);
    @(posedge clk); #1;

    // MULHU then MUL on identical operands.
    send(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE);
    wait_rsp(lat);
    @(posedge clk); #1;
    p0 = mul_pulses;
    send(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0001);
    wait_rsp(lat);
    @(posedge clk); #1;
`ifdef MUL_CTRL_FUSE_EN
    chk("fuse_latency", 64'(lat), 64'd1);
    chk("fuse_no_issue", 64'(mul_pulses - p0), 64'd0);
`else
    chk("repeat_latency", 64'(lat), 64'd36);
    chk("repeat_issue", 64'(mul_pulses - p0), 64'd1);
`endif

    rand_rdy = 1'b1;
    a = '0; b = '0;
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      if (i == 0 || $urandom_range(0, 3) != 0) begin
        a = pick();
        b = pick();
      end
      send(op, a, b, 5'($urandom_range(0, 31)), ref_mul(op, a, b));
    end
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    rand_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
